instruction_memory_loadable: RTL and testbench
==============================================

INSTRUCTION_MEMORY_LOADABLE -- requirements
Module: instruction_memory_loadable

Interface
REQ-001 The block SHALL have parameter L, default 16, giving the instruction word width and the Address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the number of storable instruction words (DEPTH >= 2).
REQ-003 The block SHALL have port Clock, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port ResetN, input, 1 bit, the reset; it is synchronous and active-low.
REQ-005 The block SHALL have port LoadValid, input, 1 bit, meaning a program word is offered on LoadData.
REQ-006 The block SHALL have port LoadData, input, L bits, meaning the program word to store.
REQ-007 The block SHALL have port LoadReady, output, 1 bit, meaning a program word will be accepted this cycle.
REQ-008 The block SHALL have port LoadDone, input, 1 bit, meaning the end of program loading.
REQ-009 The block SHALL have port LoadCount, output, clog2(DEPTH+1) bits, giving the number of words stored.
REQ-010 The block SHALL have port Overflow, output, 1 bit, a sticky flag for a word offered while the memory is full.
REQ-011 The block SHALL have port FetchReq, input, 1 bit, meaning an instruction read is requested.
REQ-012 The block SHALL have port Address, input, L bits, giving the word address of the fetch.
REQ-013 The block SHALL have port Instruction, output, L bits, giving the registered fetch result.
REQ-014 The block SHALL have port InstrValid, output, 1 bit, which pulses for one cycle when Instruction carries a new fetch result.

Function
REQ-015 The block SHALL implement a two-state machine with states LOAD and RUN; LOAD is entered from reset.
REQ-016 In LOAD, LoadReady SHALL be 1 exactly when LoadCount < DEPTH; in RUN, LoadReady SHALL be 0.
REQ-017 In LOAD, if LoadValid and LoadReady are both 1, the block SHALL write LoadData to location LoadCount and increment LoadCount by 1.
REQ-018 In LOAD, if LoadValid is 1 while LoadCount == DEPTH, the block SHALL drop the word, leave LoadCount unchanged and set Overflow to 1.
REQ-019 Overflow SHALL remain 1 until reset.
REQ-020 In LOAD, LoadDone SHALL move the state to RUN on the next edge.
REQ-021 If LoadValid and LoadDone are 1 in the same cycle, the word SHALL be accepted under the normal rules before the state changes to RUN.
REQ-022 In RUN, LoadValid and LoadDone SHALL be ignored; only reset returns the state to LOAD.
REQ-023 In LOAD, FetchReq SHALL be ignored: InstrValid stays 0 and Instruction holds its value.
REQ-024 In RUN, FetchReq=1 at edge n SHALL produce Instruction = mem[Address] and InstrValid=1 after edge n, giving 1-cycle latency.
REQ-025 Address SHALL be compared at its full L-bit width: if Address >= LoadCount (which covers Address >= DEPTH), Instruction SHALL be 0 and InstrValid SHALL still be 1.
REQ-026 Fetches SHALL be fully pipelined: FetchReq held high gives one result per cycle, each for the address presented at the preceding edge.
REQ-027 In RUN, FetchReq=0 SHALL give InstrValid=0 after the edge while Instruction holds its last value.
REQ-028 The storage array SHALL NOT be cleared by reset; locations at or above LoadCount SHALL be unreadable and return 0 per REQ-025.

Reset
REQ-029 While ResetN=0 at a rising edge, the block SHALL set: state=LOAD, LoadCount=0, Overflow=0, Instruction=0, InstrValid=0; LoadReady then reads 1.
REQ-030 Reset SHALL take priority over all other inputs in the same cycle.
REQ-031 Reset asserted mid-load or mid-fetch SHALL abandon the operation: after reset no previously loaded word is readable and no pending InstrValid appears.

Verification
REQ-032 Load 0x1111, 0x2222, 0x3333, then LoadDone; fetch addresses 0, 1, 2, 3 back-to-back -> Instruction 0x1111, 0x2222, 0x3333, 0x0000 on consecutive cycles with InstrValid=1 each cycle; LoadCount=3.
REQ-033 Load DEPTH=32 words with value 16'hA000+i, then offer a 33rd word 0xFFFF -> LoadReady=0 after the 32nd word, Overflow=1, LoadCount=32; fetch address 31 -> 0xA01F.
REQ-034 Assert LoadValid=1 (0xBEEF) and LoadDone=1 in the same cycle at LoadCount=5 -> LoadCount=6, state RUN, fetch address 5 -> 0xBEEF.
REQ-035 Assert FetchReq with Address 0 during LOAD -> InstrValid stays 0; in RUN, fetch address 0xFFFF -> Instruction=0, InstrValid=1.
REQ-036 Load 4 words, reset (ResetN=0 for 1 edge), load 1 word 0x0042, LoadDone, then fetch addresses 0 and 1 -> 0x0042 then 0x0000; Overflow=0.
REQ-037 In RUN, apply FetchReq pattern 1,0,1 -> InstrValid pattern 1,0,1 one cycle later, with Instruction held during the 0 cycle.

Source files
------------

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction store: words are streamed in during LOAD, then read back
// with a registered, fully pipelined fetch port during RUN.
module instruction_memory_loadable #(
   parameter int unsigned L     = 16,
   parameter int unsigned DEPTH = 32
) (
   input  logic                         Clock,
   input  logic                         ResetN,
   input  logic                         LoadValid,
   input  logic [L-1:0]                 LoadData,
   output logic                         LoadReady,
   input  logic                         LoadDone,
   output logic [$clog2(DEPTH+1)-1:0]   LoadCount,
   output logic                         Overflow,
   input  logic                         FetchReq,
   input  logic [L-1:0]                 Address,
   output logic [L-1:0]                 Instruction,
   output logic                         InstrValid
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned AW = (L > CW) ? L : CW;

   typedef enum logic {LOAD, RUN} state_t;

   state_t         state;
   logic [L-1:0]   mem [DEPTH];
   logic [AW-1:0]  addr_ext;
   logic [AW-1:0]  count_ext;
   logic [IW-1:0]  rd_idx;
   logic [IW-1:0]  wr_idx;
   logic           full;
   logic           accept;
   logic           in_range;

   // Address is compared at full width so out-of-range fetches never alias into the array.
   assign addr_ext  = AW'(Address);
   assign count_ext = AW'(LoadCount);
   assign in_range  = addr_ext < count_ext;
   assign rd_idx    = IW'(Address);
   assign wr_idx    = IW'(LoadCount);

   assign full      = (LoadCount == CW'(DEPTH));
   assign LoadReady = (state == LOAD) && !full;
   assign accept    = LoadValid && LoadReady;

   // Storage is deliberately not reset; LoadCount gates what is readable.
   always_ff @(posedge Clock) begin
      if (ResetN && accept) begin
         mem[wr_idx] <= LoadData;
      end
   end

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state       <= LOAD;
         LoadCount   <= '0;
         Overflow    <= 1'b0;
         Instruction <= '0;
         InstrValid  <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               InstrValid <= 1'b0;
               if (accept) begin
                  LoadCount <= LoadCount + CW'(1);
               end
               if (LoadValid && full) begin
                  Overflow <= 1'b1;
               end
               if (LoadDone) begin
                  state <= RUN;
               end
            end
            RUN: begin
               InstrValid <= FetchReq;
               if (FetchReq) begin
                  Instruction <= in_range ? mem[rd_idx] : '0;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Scoreboard bench for instruction_memory_loadable: a behavioural model queues
// expected fetch results as requests are driven and retires them on InstrValid.
module tb_instruction_memory_loadable;

   localparam int unsigned L     = 16;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          Clock;
   logic          ResetN;
   logic          LoadValid;
   logic [L-1:0]  LoadData;
   logic          LoadReady;
   logic          LoadDone;
   logic [CW-1:0] LoadCount;
   logic          Overflow;
   logic          FetchReq;
   logic [L-1:0]  Address;
   logic [L-1:0]  Instruction;
   logic          InstrValid;

   instruction_memory_loadable #(.L(L), .DEPTH(DEPTH)) dut (
      .Clock       (Clock),
      .ResetN      (ResetN),
      .LoadValid   (LoadValid),
      .LoadData    (LoadData),
      .LoadReady   (LoadReady),
      .LoadDone    (LoadDone),
      .LoadCount   (LoadCount),
      .Overflow    (Overflow),
      .FetchReq    (FetchReq),
      .Address     (Address),
      .Instruction (Instruction),
      .InstrValid  (InstrValid)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int unsigned   n_checks = 0;
   int unsigned   n_fail   = 0;

   // Reference model state
   logic [L-1:0]  model_mem [DEPTH];
   int unsigned   model_cnt  = 0;
   bit            model_run  = 0;
   bit            model_ovf  = 0;
   logic [L-1:0]  last_instr = '0;
   logic [L-1:0]  exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock with the currently driven inputs, updating the model first.
   task automatic step();
      bit           fire;
      logic [L-1:0] exp;
      fire = 0;
      if (!ResetN) begin
         model_run  = 0;
         model_cnt  = 0;
         model_ovf  = 0;
         last_instr = '0;
         exp_q.delete();
      end else begin
         fire = model_run && FetchReq;
         if (fire) begin
            exp = (int'(Address) < model_cnt) ? model_mem[int'(Address)] : '0;
            exp_q.push_back(exp);
         end
         if (!model_run) begin
            if (LoadValid) begin
               if (model_cnt < DEPTH) begin
                  model_mem[model_cnt] = LoadData;
                  model_cnt++;
               end else begin
                  model_ovf = 1;
               end
            end
            if (LoadDone) model_run = 1;
         end
      end
      @(posedge Clock);
      #1;
      check("instr_valid", 32'(InstrValid), 32'(fire));
      if (InstrValid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(Instruction), 32'hFFFF_FFFF);
         end else begin
            exp = exp_q.pop_front();
            check("instruction", 32'(Instruction), 32'(exp));
            last_instr = exp;
         end
      end else begin
         check("instr_hold", 32'(Instruction), 32'(last_instr));
      end
      check("load_count", 32'(LoadCount), model_cnt);
      check("overflow", 32'(Overflow), 32'(model_ovf));
      check("load_ready", 32'(LoadReady), 32'(!model_run && model_cnt < DEPTH));
   endtask

   task automatic drive(input bit rst_n, input bit lv, input logic [L-1:0] ld,
                        input bit done, input bit fr, input logic [L-1:0] addr);
      ResetN    = rst_n;
      LoadValid = lv;
      LoadData  = ld;
      LoadDone  = done;
      FetchReq  = fr;
      Address   = addr;
      step();
   endtask

   task automatic do_reset();
      drive(0, 0, '0, 0, 0, '0);
   endtask

   initial begin
      ResetN = 0; LoadValid = 0; LoadData = '0; LoadDone = 0; FetchReq = 0; Address = '0;
      do_reset();

      // Basic load, fetch ignored during LOAD, back-to-back fetches, out-of-range address
      drive(1, 1, 16'h1111, 0, 1, 16'h0000);
      drive(1, 1, 16'h2222, 0, 1, 16'h0000);
      drive(1, 1, 16'h3333, 0, 0, '0);
      drive(1, 0, '0, 1, 0, '0);
      for (int i = 0; i < 4; i++) drive(1, 0, '0, 0, 1, L'(i));
      drive(1, 0, '0, 0, 1, 16'hFFFF);
      drive(1, 0, '0, 0, 0, '0);
      // RUN ignores load traffic; FetchReq pattern 1,0,1
      drive(1, 1, 16'hDEAD, 1, 1, 16'h0001);
      drive(1, 0, '0, 0, 0, 16'h0002);
      drive(1, 0, '0, 0, 1, 16'h0002);
      drive(1, 0, '0, 0, 0, '0);

      // Reset wins over a pending fetch; then reset mid-load discards earlier words
      drive(0, 0, '0, 0, 1, 16'h0000);
      for (int i = 0; i < 4; i++) drive(1, 1, L'(16'h0500 + i), 0, 0, '0);
      do_reset();
      drive(1, 1, 16'h0042, 0, 0, '0);
      drive(1, 0, '0, 1, 0, '0);
      drive(1, 0, '0, 0, 1, 16'h0000);
      drive(1, 0, '0, 0, 1, 16'h0001);
      drive(1, 0, '0, 0, 0, '0);

      // Fill to DEPTH, then overflow
      do_reset();
      for (int i = 0; i < DEPTH; i++) drive(1, 1, L'(16'hA000 + i), 0, 0, '0);
      drive(1, 1, 16'hFFFF, 0, 0, '0);
      drive(1, 0, '0, 0, 0, '0);
      drive(1, 0, '0, 1, 0, '0);
      drive(1, 0, '0, 0, 1, 16'd31);
      drive(1, 0, '0, 0, 1, 16'd32);
      drive(1, 0, '0, 0, 1, 16'd0);
      drive(1, 0, '0, 0, 0, '0);

      // Word accepted in the same cycle as LoadDone
      do_reset();
      for (int i = 0; i < 5; i++) drive(1, 1, L'(16'h0C00 + i), 0, 0, '0);
      drive(1, 1, 16'hBEEF, 1, 0, '0);
      drive(1, 0, '0, 0, 1, 16'd5);
      drive(1, 0, '0, 0, 1, 16'd6);
      drive(1, 0, '0, 0, 1, 16'd4);
      drive(1, 0, '0, 0, 0, '0);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
